// File: rtl/niosii_soc_nios2_oci_dct_pkg.sv
// Shared definitions for the OCI direct-compression-trace buffer controller:
// default geometry and the controller state encoding.
package niosii_soc_nios2_oci_dct_pkg;

    localparam int TOKEN_W_DEF = 2;
    localparam int SLOTS_DEF   = 15;
    localparam int BUF_W_DEF   = 30;
    localparam int CNT_W_DEF   = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_EMIT  = 2'd1,
        ST_ENDED = 2'd2
    } dct_state_e;

endpackage

// File: rtl/niosii_soc_nios2_oci_dct_packer.sv
// Token packer: writes accepted tokens into the next free slot, keeps the
// slot count, and clears both when the presented word is consumed.
module niosii_soc_nios2_oci_dct_packer
    import niosii_soc_nios2_oci_dct_pkg::*;
#(
    parameter int TOKEN_W = TOKEN_W_DEF,
    parameter int SLOTS   = SLOTS_DEF,
    parameter int BUF_W   = BUF_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [TOKEN_W-1:0] wr_data,
    input  logic               clear,
    output logic [BUF_W-1:0]   buffer,
    output logic [CNT_W-1:0]   count,
    output logic [CNT_W-1:0]   count_next
);

    logic [BUF_W-1:0] buffer_r;
    logic [BUF_W-1:0] buffer_next_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;

    // Next buffer/count: clear wins; a write lands in slot count_r only when a slot is free.
    always_comb begin
        buffer_next_s = buffer_r;
        count_next_s  = count_r;
        if (clear) begin
            buffer_next_s = '0;
            count_next_s  = '0;
        end else if (wr_en && (count_r < CNT_W'(SLOTS))) begin
            for (int i = 0; i < SLOTS; i++) begin
                if (count_r == CNT_W'(i)) begin
                    buffer_next_s[i*TOKEN_W +: TOKEN_W] = wr_data;
                end else begin
                    buffer_next_s[i*TOKEN_W +: TOKEN_W] = buffer_r[i*TOKEN_W +: TOKEN_W];
                end
            end
            count_next_s = count_r + CNT_W'(1);
        end else begin
            buffer_next_s = buffer_r;
            count_next_s  = count_r;
        end
    end

    // Buffer and count registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer_r <= '0;
            count_r  <= '0;
        end else begin
            buffer_r <= buffer_next_s;
            count_r  <= count_next_s;
        end
    end

    assign buffer     = buffer_r;
    assign count      = count_r;
    assign count_next = count_next_s;

endmodule

// File: rtl/niosii_soc_nios2_oci_dct_ctrl.sv
// DCT buffer controller: collects trace tokens into a word, presents full or
// flushed words downstream with a valid/ready handshake, and handles shutdown.
module niosii_soc_nios2_oci_dct_ctrl
    import niosii_soc_nios2_oci_dct_pkg::*;
#(
    parameter int TOKEN_W = TOKEN_W_DEF,
    parameter int SLOTS   = SLOTS_DEF,
    parameter int BUF_W   = BUF_W_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tok_valid,
    input  logic [TOKEN_W-1:0] tok_data,
    output logic               tok_ready,
    input  logic               flush_req,
    input  logic               test_ending,
    output logic [BUF_W-1:0]   dct_buffer,
    output logic [CNT_W-1:0]   dct_count,
    output logic               dct_valid,
    input  logic               dct_ready,
    output logic               test_has_ended,
    output logic               busy
);

    dct_state_e       state_r;
    dct_state_e       state_next_s;
    logic             end_pending_r;
    logic             end_pending_next_s;
    logic             accept_s;
    logic             clear_s;
    logic [CNT_W-1:0] count_next_s;
    logic             tok_ready_r;
    logic             dct_valid_r;
    logic             ended_r;
    logic             busy_r;
    logic             tok_ready_s;
    logic             dct_valid_s;
    logic             ended_s;
    logic             busy_s;

    assign accept_s = (state_r == ST_FILL) && tok_valid;
    assign clear_s  = (state_r == ST_EMIT) && dct_ready;

    niosii_soc_nios2_oci_dct_packer #(
        .TOKEN_W (TOKEN_W),
        .SLOTS   (SLOTS),
        .BUF_W   (BUF_W),
        .CNT_W   (CNT_W)
    ) u_packer (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (accept_s),
        .wr_data    (tok_data),
        .clear      (clear_s),
        .buffer     (dct_buffer),
        .count      (dct_count),
        .count_next (count_next_s)
    );

    // State and sticky end-pending registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= ST_FILL;
            end_pending_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            end_pending_r <= end_pending_next_s;
        end
    end

    // Next state; count_next already includes a token accepted this cycle.
    always_comb begin
        state_next_s       = state_r;
        end_pending_next_s = end_pending_r;
        case (state_r)
            ST_FILL: begin
                if (test_ending) begin
                    end_pending_next_s = 1'b1;
                    if (count_next_s != '0) begin
                        state_next_s = ST_EMIT;
                    end else begin
                        state_next_s = ST_ENDED;
                    end
                end else if (count_next_s == CNT_W'(SLOTS)) begin
                    state_next_s = ST_EMIT;
                end else if (flush_req && (count_next_s != '0)) begin
                    state_next_s = ST_EMIT;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_EMIT: begin
                end_pending_next_s = end_pending_r | test_ending;
                if (dct_ready) begin
                    if (end_pending_r || test_ending) begin
                        state_next_s = ST_ENDED;
                    end else begin
                        state_next_s = ST_FILL;
                    end
                end else begin
                    state_next_s = ST_EMIT;
                end
            end
            ST_ENDED: begin
                state_next_s = ST_ENDED;
            end
            default: begin
                state_next_s = ST_FILL;
            end
        endcase
    end

    // Output decode from the next state so the flags register alongside it.
    always_comb begin
        tok_ready_s = 1'b0;
        dct_valid_s = 1'b0;
        ended_s     = 1'b0;
        case (state_next_s)
            ST_FILL:  tok_ready_s = 1'b1;
            ST_EMIT:  dct_valid_s = 1'b1;
            ST_ENDED: ended_s     = 1'b1;
            default:  tok_ready_s = 1'b0;
        endcase
        busy_s = (count_next_s != '0) || (state_next_s != ST_FILL);
    end

    // Registered handshake and status outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tok_ready_r <= 1'b1;
            dct_valid_r <= 1'b0;
            ended_r     <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            tok_ready_r <= tok_ready_s;
            dct_valid_r <= dct_valid_s;
            ended_r     <= ended_s;
            busy_r      <= busy_s;
        end
    end

    assign tok_ready      = tok_ready_r;
    assign dct_valid      = dct_valid_r;
    assign test_has_ended = ended_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_niosii_soc_nios2_oci_dct_ctrl.sv
// Bench for the DCT buffer controller: directed vector table, hand-written
// corner sequences, and a randomized run against a queue-based word model.
module tb_niosii_soc_nios2_oci_dct_ctrl;

    localparam int TOKEN_W = 2;
    localparam int SLOTS   = 15;
    localparam int BUF_W   = 30;
    localparam int CNT_W   = 4;

    logic               clk = 1'b0;
    logic               reset;
    logic               tok_valid;
    logic [TOKEN_W-1:0] tok_data;
    logic               tok_ready;
    logic               flush_req;
    logic               test_ending;
    logic [BUF_W-1:0]   dct_buffer;
    logic [CNT_W-1:0]   dct_count;
    logic               dct_valid;
    logic               dct_ready;
    logic               test_has_ended;
    logic               busy;

    int total = 0;
    int bad   = 0;

    niosii_soc_nios2_oci_dct_ctrl #(
        .TOKEN_W (TOKEN_W),
        .SLOTS   (SLOTS),
        .BUF_W   (BUF_W),
        .CNT_W   (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .tok_valid      (tok_valid),
        .tok_data       (tok_data),
        .tok_ready      (tok_ready),
        .flush_req      (flush_req),
        .test_ending    (test_ending),
        .dct_buffer     (dct_buffer),
        .dct_count      (dct_count),
        .dct_valid      (dct_valid),
        .dct_ready      (dct_ready),
        .test_has_ended (test_has_ended),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tv;
        logic [1:0]  td;
        logic        fl;
        logic        te;
        logic        dr;
        logic        e_rdy;
        logic        e_val;
        logic [29:0] e_buf;
        logic [3:0]  e_cnt;
        logic        e_end;
    } vec_t;

    vec_t tbl[13];

    // Word model: tokens of the current word, plus presenting / end flags.
    logic [1:0] m_q[$];
    bit m_pres;
    bit m_endp;
    bit m_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [29:0] m_pack();
        logic [29:0] w;
        w = 30'h0;
        for (int i = 0; i < m_q.size(); i++) begin
            w = w | (30'(m_q[i]) << (2 * i));
        end
        return w;
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_pres = 1'b0;
        m_endp = 1'b0;
        m_done = 1'b0;
    endtask

    // Advance the model by one clock using the inputs that were present at the edge.
    task automatic model_step();
        if (m_done) begin
        end else if (m_pres) begin
            if (test_ending) m_endp = 1'b1;
            if (dct_ready) begin
                m_q.delete();
                m_pres = 1'b0;
                if (m_endp) m_done = 1'b1;
            end
        end else begin
            if (tok_valid) m_q.push_back(tok_data);
            if (test_ending) begin
                m_endp = 1'b1;
                if (m_q.size() > 0) m_pres = 1'b1;
                else m_done = 1'b1;
            end else if (m_q.size() == SLOTS) begin
                m_pres = 1'b1;
            end else if (flush_req && m_q.size() > 0) begin
                m_pres = 1'b1;
            end
        end
    endtask

    task automatic model_check(input int cyc);
        chk($sformatf("rnd%0d tok_ready", cyc), 32'(tok_ready), 32'(!m_pres && !m_done));
        chk($sformatf("rnd%0d dct_valid", cyc), 32'(dct_valid), 32'(m_pres));
        chk($sformatf("rnd%0d dct_buffer", cyc), 32'(dct_buffer), 32'(m_pack()));
        chk($sformatf("rnd%0d dct_count", cyc), 32'(dct_count), 32'(m_q.size()));
        chk($sformatf("rnd%0d ended", cyc), 32'(test_has_ended), 32'(m_done));
        chk($sformatf("rnd%0d busy", cyc), 32'(busy), 32'((m_q.size() != 0) || m_pres || m_done));
    endtask

    task automatic drive(input logic tv, input logic [1:0] td, input logic fl,
                         input logic te, input logic dr);
        tok_valid   = tv;
        tok_data    = td;
        flush_req   = fl;
        test_ending = te;
        dct_ready   = dr;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    logic [29:0] exp_w;
    logic [1:0]  tk;
    int          done_cnt;

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 1'b0};
        tbl[1]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 30'h0,  4'd0, 1'b0};
        tbl[2]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h3,  4'd1, 1'b0};
        tbl[3]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'hF,  4'd2, 1'b0};
        tbl[4]  = '{1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 30'h3F, 4'd3, 1'b0};
        tbl[5]  = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 30'h3F, 4'd3, 1'b0};
        for (int i = 6; i <= 10; i++) begin
            tbl[i] = '{1'b1, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 30'h3F, 4'd3, 1'b0};
        end
        tbl[11] = '{1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,  4'd0, 1'b0};
        tbl[12] = '{1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 30'h0,  4'd0, 1'b0};

        // Reset state
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst dct_valid", 32'(dct_valid), 32'd0);
        chk("rst dct_count", 32'(dct_count), 32'd0);
        chk("rst dct_buffer", 32'(dct_buffer), 32'd0);
        chk("rst ended", 32'(test_has_ended), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        cyc();
        cyc();
        reset = 1'b0;
        chk("rst tok_ready", 32'(tok_ready), 32'd1);

        // Directed table: empty flush, partial flush held under backpressure
        foreach (tbl[i]) begin
            drive(tbl[i].tv, tbl[i].td, tbl[i].fl, tbl[i].te, tbl[i].dr);
            cyc();
            chk($sformatf("tbl%0d tok_ready", i), 32'(tok_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d dct_valid", i), 32'(dct_valid), 32'(tbl[i].e_val));
            chk($sformatf("tbl%0d dct_buffer", i), 32'(dct_buffer), 32'(tbl[i].e_buf));
            chk($sformatf("tbl%0d dct_count", i), 32'(dct_count), 32'(tbl[i].e_cnt));
            chk($sformatf("tbl%0d ended", i), 32'(test_has_ended), 32'(tbl[i].e_end));
        end

        // 15 back-to-back tokens with downstream always ready
        for (int i = 0; i < SLOTS; i++) begin
            drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
            cyc();
            if (i < SLOTS - 1) begin
                chk($sformatf("full%0d dct_valid", i), 32'(dct_valid), 32'd0);
                chk($sformatf("full%0d dct_count", i), 32'(dct_count), 32'(i + 1));
            end
        end
        chk("full dct_valid", 32'(dct_valid), 32'd1);
        chk("full dct_buffer", 32'(dct_buffer), 32'h15555555);
        chk("full dct_count", 32'(dct_count), 32'd15);
        chk("full tok_ready", 32'(tok_ready), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("full after dct_valid", 32'(dct_valid), 32'd0);
        chk("full after dct_count", 32'(dct_count), 32'd0);
        chk("full after tok_ready", 32'(tok_ready), 32'd1);
        chk("full after busy", 32'(busy), 32'd0);

        // Shutdown with a token accepted in the same cycle as test_ending
        drive(1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        cyc();
        drive(1'b1, 2'b11, 1'b0, 1'b1, 1'b0);
        cyc();
        chk("end dct_valid", 32'(dct_valid), 32'd1);
        chk("end dct_count", 32'(dct_count), 32'd3);
        chk("end dct_buffer", 32'(dct_buffer), 32'h36);
        chk("end ended early", 32'(test_has_ended), 32'd0);
        drive(1'b0, 2'b00, 1'b0, 1'b1, 1'b1);
        cyc();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("ended%0d ended", i), 32'(test_has_ended), 32'd1);
            chk($sformatf("ended%0d tok_ready", i), 32'(tok_ready), 32'd0);
            chk($sformatf("ended%0d dct_valid", i), 32'(dct_valid), 32'd0);
            chk($sformatf("ended%0d dct_count", i), 32'(dct_count), 32'd0);
            drive(1'b1, 2'b11, 1'b1, 1'b0, 1'b1);
            cyc();
        end

        // Reset while a full word is being presented
        do_reset();
        chk("rr tok_ready", 32'(tok_ready), 32'd1);
        chk("rr ended", 32'(test_has_ended), 32'd0);
        for (int i = 0; i < SLOTS; i++) begin
            drive(1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
            cyc();
        end
        chk("rr emit dct_valid", 32'(dct_valid), 32'd1);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        chk("rr async dct_valid", 32'(dct_valid), 32'd0);
        chk("rr async dct_count", 32'(dct_count), 32'd0);
        chk("rr async dct_buffer", 32'(dct_buffer), 32'd0);
        chk("rr async ended", 32'(test_has_ended), 32'd0);
        chk("rr async busy", 32'(busy), 32'd0);
        cyc();
        reset = 1'b0;
        exp_w = 30'h0;
        for (int i = 0; i < SLOTS; i++) begin
            tk = 2'($urandom);
            exp_w = exp_w | (30'(tk) << (2 * i));
            drive(1'b1, tk, 1'b0, 1'b0, 1'b1);
            cyc();
        end
        chk("rr run dct_valid", 32'(dct_valid), 32'd1);
        chk("rr run dct_buffer", 32'(dct_buffer), 32'(exp_w));
        chk("rr run dct_count", 32'(dct_count), 32'd15);
        drive(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        cyc();
        chk("rr run done dct_valid", 32'(dct_valid), 32'd0);

        // Randomized traffic against the word model
        do_reset();
        model_reset();
        done_cnt = 0;
        for (int c = 0; c < 4000; c++) begin
            drive(1'($urandom_range(0, 3) != 0), 2'($urandom),
                  1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 299) == 0),
                  1'($urandom_range(0, 2) != 0));
            cyc();
            model_step();
            model_check(c);
            if (m_done) begin
                done_cnt++;
                if (done_cnt > 3) begin
                    do_reset();
                    model_reset();
                    done_cnt = 0;
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
